// File: rtl/fir_line_sequencer_if.sv
// Pixel stream input and filter column output bundle of fir_line_sequencer.
// The master side is the pixel source and filter; the slave side is the sequencer.
interface fir_line_sequencer_if;
    logic [7:0] s_pixel;
    logic       s_valid;
    logic       s_sof;
    logic       s_ready;
    logic [7:0] pixel0;
    logic [7:0] pixel1;
    logic [7:0] pixel2;
    logic [7:0] pixel3;
    logic [7:0] pixel4;
    logic       fir_valid;
    logic       busy;
    logic       frame_done;
    logic       sof_err;

    modport master (
        output s_pixel, s_valid, s_sof,
        input  s_ready, pixel0, pixel1, pixel2, pixel3, pixel4,
        input  fir_valid, busy, frame_done, sof_err
    );

    modport slave (
        input  s_pixel, s_valid, s_sof,
        output s_ready, pixel0, pixel1, pixel2, pixel3, pixel4,
        output fir_valid, busy, frame_done, sof_err
    );
endinterface

// File: rtl/fir_line_sequencer.sv
// Raster-to-column front end for the 5x5 systolic FIR: four chained line buffers,
// frame sequencing FSM, end-of-frame flush timer and premature start-of-frame detection.
module fir_line_sequencer #(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int FLUSH_CYCLES = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_line_sequencer_if.slave  bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [CW-1:0] COL_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] COL_ONE    = CW'(1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_ZERO   = {RW{1'b0}};
    localparam logic [RW-1:0] ROW_ONE    = RW'(1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_VALID  = RW'(4);
    localparam logic [FW-1:0] FLUSH_ZERO = {FW{1'b0}};
    localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d, cur_col_s;
    logic [RW-1:0] row_q, row_d, cur_row_s;
    logic [FW-1:0] flush_q, flush_d;
    logic          s_ready_q, s_ready_d;
    logic          fir_valid_q, fir_valid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          sof_err_q, sof_err_d;
    logic [7:0]    pix_q [5];
    logic [7:0]    pix_d [5];
    logic          accept_s;
    logic          restart_s;
    logic          beat_s;

    logic [7:0]    lb3 [IMG_WIDTH];
    logic [7:0]    lb2 [IMG_WIDTH];
    logic [7:0]    lb1 [IMG_WIDTH];
    logic [7:0]    lb0 [IMG_WIDTH];

    assign accept_s  = bus.s_valid && s_ready_q;
    assign restart_s = accept_s && bus.s_sof;

    // Next-state, position, flush timer and output-register load logic.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        flush_d      = flush_q;
        fir_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;
        pix_d        = pix_q;
        beat_s       = 1'b0;
        // A start-of-frame beat always lands at (0,0), whatever the counters held.
        cur_col_s    = restart_s ? COL_ZERO : col_q;
        cur_row_s    = restart_s ? ROW_ZERO : row_q;

        case (state_q)
            ST_IDLE: begin
                beat_s = restart_s;
            end
            ST_RUN: begin
                beat_s = accept_s;
                if (restart_s && ((col_q != COL_ZERO) || (row_q != ROW_ZERO))) begin
                    sof_err_d = 1'b1;
                end else begin
                    sof_err_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (flush_q == FLUSH_ONE) begin
                    frame_done_d = 1'b1;
                    flush_d      = FLUSH_ZERO;
                    state_d      = ST_IDLE;
                end else begin
                    flush_d      = flush_q - FLUSH_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (beat_s) begin
            pix_d[4]    = bus.s_pixel;
            pix_d[3]    = lb3[cur_col_s];
            pix_d[2]    = lb2[cur_col_s];
            pix_d[1]    = lb1[cur_col_s];
            pix_d[0]    = lb0[cur_col_s];
            fir_valid_d = (cur_row_s >= ROW_VALID);
            state_d     = ST_RUN;
            if (cur_col_s == COL_LAST) begin
                col_d = COL_ZERO;
                if (cur_row_s == ROW_LAST) begin
                    row_d   = ROW_ZERO;
                    flush_d = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                end else begin
                    row_d   = cur_row_s + ROW_ONE;
                end
            end else begin
                col_d = cur_col_s + COL_ONE;
                row_d = cur_row_s;
            end
        end else begin
            fir_valid_d = 1'b0;
        end

        // Ready stays low for one extra cycle after FLUSH so the frame_done cycle never overlaps an accept.
        s_ready_d = (state_d != ST_FLUSH) && (state_q != ST_FLUSH);
        busy_d    = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            col_q        <= COL_ZERO;
            row_q        <= ROW_ZERO;
            flush_q      <= FLUSH_ZERO;
            s_ready_q    <= 1'b0;
            fir_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                pix_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            flush_q      <= flush_d;
            s_ready_q    <= s_ready_d;
            fir_valid_q  <= fir_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
            pix_q        <= pix_d;
        end
    end

    // Line buffer chain: read-before-write shift of one column per written beat; contents are never reset.
    always_ff @(posedge clk) begin
        if (beat_s) begin
            lb3[cur_col_s] <= bus.s_pixel;
            lb2[cur_col_s] <= lb3[cur_col_s];
            lb1[cur_col_s] <= lb2[cur_col_s];
            lb0[cur_col_s] <= lb1[cur_col_s];
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.fir_valid  = fir_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sof_err    = sof_err_q;
    assign bus.pixel0     = pix_q[0];
    assign bus.pixel1     = pix_q[1];
    assign bus.pixel2     = pix_q[2];
    assign bus.pixel3     = pix_q[3];
    assign bus.pixel4     = pix_q[4];
endmodule

// File: tb/tb_fir_line_sequencer.sv
// Self-checking bench for fir_line_sequencer: randomized frames against a
// frame-image reference model, plus fixed-pattern checks of columns and flush timing.
module tb_fir_line_sequencer;
    localparam int W = 8;
    localparam int H = 6;
    localparam int F = 12;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_FLUSH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_line_sequencer_if bus ();

    fir_line_sequencer #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .FLUSH_CYCLES (F)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame position, a copy of the frame image and expected outputs.
    int          m_state, m_row, m_col, m_flush;
    bit          m_rdy, m_fv, m_busy, m_done, m_err;
    logic [7:0]  m_px [5];
    logic [7:0]  img [H][W];
    logic [4:0]  obs_ctl, exp_ctl;   // {s_ready, fir_valid, busy, frame_done, sof_err}
    logic [39:0] obs_px, exp_px;     // {pixel0 .. pixel4}

    task automatic model_reset();
        m_state = S_IDLE; m_row = 0; m_col = 0; m_flush = 0;
        m_rdy = 1'b0; m_fv = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        for (int k = 0; k < 5; k++) m_px[k] = 8'h00;
    endtask

    // Drive one cycle, advance the model across the edge, then sample the DUT 1 time unit later.
    task automatic step(input bit v, input bit sof, input logic [7:0] p, output bit acc);
        int prev;
        bus.s_valid = v; bus.s_sof = sof; bus.s_pixel = p;
        @(posedge clk);
        prev   = m_state;
        acc    = v && m_rdy;
        m_fv   = 1'b0; m_done = 1'b0; m_err = 1'b0;
        if (m_state == S_FLUSH) begin
            if (m_flush == 1) begin m_done = 1'b1; m_state = S_IDLE; end
            else m_flush--;
        end else if (acc && (sof || m_state == S_RUN)) begin
            if (sof) begin
                m_err = (m_state == S_RUN) && (m_row != 0 || m_col != 0);
                m_row = 0; m_col = 0;
            end
            img[m_row][m_col] = p;
            m_px[4] = p;
            if (m_row >= 4) begin
                m_fv = 1'b1;
                for (int k = 0; k < 4; k++) m_px[k] = img[m_row - 4 + k][m_col];
            end
            m_state = S_RUN;
            m_col++;
            if (m_col == W) begin
                m_col = 0; m_row++;
                if (m_row == H) begin m_row = 0; m_state = S_FLUSH; m_flush = F; end
            end
        end
        m_busy = (m_state != S_IDLE);
        m_rdy  = (m_state != S_FLUSH) && (prev != S_FLUSH);
        #1;
        obs_ctl = {bus.s_ready, bus.fir_valid, bus.busy, bus.frame_done, bus.sof_err};
        exp_ctl = {m_rdy, m_fv, m_busy, m_done, m_err};
        obs_px  = {bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4};
        exp_px  = {m_px[0], m_px[1], m_px[2], m_px[3], m_px[4]};
    endtask

    function automatic logic [7:0] pat(int i);
        return 8'(16 * (i / W) + (i % W));
    endfunction

    task automatic test_reset();
        bit acc;
        rst = 1'b0; bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_pixel = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.s_ready, bus.fir_valid, bus.busy, bus.frame_done, bus.sof_err,
             bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4} !== 45'd0) begin
            n_bad++; $display("FAIL reset_outputs: got nonzero output ctl=%b px=%h, want all 0",
                              {bus.s_ready, bus.fir_valid, bus.busy, bus.frame_done, bus.sof_err},
                              {bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4});
        end
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++;
        if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_early: got %b want 0", bus.s_ready); end
        step(1'b0, 1'b0, 8'h00, acc);
        n_cmp++;
        if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL reset_release: got %b want %b", obs_ctl, exp_ctl); end
    endtask

    task automatic test_basic();
        bit acc; int nfv = 0; int kd = -1; logic [39:0] first_col = 40'd0; logic [39:0] last_col = 40'd0;
        for (int i = 0; i < W * H; i++) begin
            int tries = 0; acc = 1'b0;
            while (!acc && tries < 8) begin
                step(1'b1, i == 0, pat(i), acc); tries++;
                n_cmp++;
                if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL basic_ctl @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
                if (exp_ctl[3]) begin n_cmp++; if (obs_px !== exp_px) begin n_bad++; $display("FAIL basic_col @%0t: got %h want %h", $time, obs_px, exp_px); end end
                if (obs_ctl[3] === 1'b1) begin if (nfv == 0) first_col = obs_px; last_col = obs_px; nfv++; end
            end
            if (!acc) begin n_cmp++; n_bad++; $display("FAIL basic_accept: beat %0d not accepted in %0d cycles", i, tries); end
        end
        for (int k = 1; k <= F + 3; k++) begin
            step(1'b0, 1'b0, 8'h00, acc);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL basic_drain @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
            if (obs_ctl[1] === 1'b1 && kd < 0) kd = k;
        end
        n_cmp++; if (nfv !== 16) begin n_bad++; $display("FAIL basic_fv_count: got %0d want 16", nfv); end
        n_cmp++; if (first_col !== 40'h0010203040) begin n_bad++; $display("FAIL basic_first_col: got %h want 0010203040", first_col); end
        n_cmp++; if (last_col !== 40'h1727374757) begin n_bad++; $display("FAIL basic_last_col: got %h want 1727374757", last_col); end
        n_cmp++; if (kd !== F) begin n_bad++; $display("FAIL basic_done_delay: got %0d want %0d", kd, F); end
    endtask

    task automatic test_gaps();
        bit acc; int nfv = 0;
        for (int i = 0; i < W * H; i++) begin
            int tries = 0; acc = 1'b0;
            while (!acc && tries < 40) begin
                step(1'($urandom_range(0, 1)), i == 0, 8'($urandom), acc); tries++;
                n_cmp++;
                if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL gaps_ctl @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
                if (exp_ctl[3]) begin n_cmp++; if (obs_px !== exp_px) begin n_bad++; $display("FAIL gaps_col @%0t: got %h want %h", $time, obs_px, exp_px); end end
                if (obs_ctl[3] === 1'b1) nfv++;
            end
            if (!acc) begin n_cmp++; n_bad++; $display("FAIL gaps_accept: beat %0d not accepted", i); end
        end
        for (int k = 1; k <= F + 3; k++) begin
            step(1'b0, 1'b0, 8'h00, acc);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL gaps_drain @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
        end
        n_cmp++; if (nfv !== 16) begin n_bad++; $display("FAIL gaps_fv_count: got %0d want 16", nfv); end
    endtask

    task automatic test_idle_junk();
        bit acc; int nfv = 0; logic [39:0] first_col = 40'd0;
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 1'b0, 8'($urandom), acc);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL junk_ignored @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
        end
        for (int i = 0; i < W * H; i++) begin
            int tries = 0; acc = 1'b0;
            while (!acc && tries < 8) begin
                step(1'b1, i == 0, pat(i), acc); tries++;
                n_cmp++;
                if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL junk_ctl @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
                if (exp_ctl[3]) begin n_cmp++; if (obs_px !== exp_px) begin n_bad++; $display("FAIL junk_col @%0t: got %h want %h", $time, obs_px, exp_px); end end
                if (obs_ctl[3] === 1'b1) begin if (nfv == 0) first_col = obs_px; nfv++; end
            end
            if (!acc) begin n_cmp++; n_bad++; $display("FAIL junk_accept: beat %0d not accepted", i); end
        end
        for (int k = 1; k <= F + 3; k++) begin
            step(1'b0, 1'b0, 8'h00, acc);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL junk_drain @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
        end
        n_cmp++; if (nfv !== 16) begin n_bad++; $display("FAIL junk_fv_count: got %0d want 16", nfv); end
        n_cmp++; if (first_col !== 40'h0010203040) begin n_bad++; $display("FAIL junk_first_col: got %h want 0010203040", first_col); end
    endtask

    task automatic test_premature_sof();
        bit acc; int nfv = 0; int nerr = 0;
        int first_len = 2 * W + 3;
        for (int i = 0; i < first_len + W * H; i++) begin
            int tries = 0; acc = 1'b0;
            while (!acc && tries < 8) begin
                step(1'b1, (i == 0) || (i == first_len), 8'($urandom), acc); tries++;
                n_cmp++;
                if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL sof_ctl @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
                if (exp_ctl[3]) begin n_cmp++; if (obs_px !== exp_px) begin n_bad++; $display("FAIL sof_col @%0t: got %h want %h", $time, obs_px, exp_px); end end
                if (obs_ctl[0] === 1'b1) nerr++;
                if (obs_ctl[3] === 1'b1) nfv++;
            end
            if (!acc) begin n_cmp++; n_bad++; $display("FAIL sof_accept: beat %0d not accepted", i); end
        end
        for (int k = 1; k <= F + 3; k++) begin
            step(1'b0, 1'b0, 8'h00, acc);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL sof_drain @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
        end
        n_cmp++; if (nerr !== 1) begin n_bad++; $display("FAIL sof_err_count: got %0d want 1", nerr); end
        n_cmp++; if (nfv !== 16) begin n_bad++; $display("FAIL sof_fv_count: got %0d want 16", nfv); end
    endtask

    task automatic test_reset_mid();
        bit acc; int nfv = 0; logic [39:0] first_col = 40'd0; logic [39:0] last_col = 40'd0;
        for (int i = 0; i < 5 * W + 2; i++) begin
            step(1'b1, i == 0, pat(i), acc);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL rstmid_pre @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.s_ready, bus.fir_valid, bus.busy, bus.frame_done, bus.sof_err,
             bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4} !== 45'd0) begin
            n_bad++; $display("FAIL rstmid_async_clear: got ctl=%b px=%h want all 0",
                              {bus.s_ready, bus.fir_valid, bus.busy, bus.frame_done, bus.sof_err},
                              {bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4});
        end
        model_reset();
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < W * H; i++) begin
            int tries = 0; acc = 1'b0;
            while (!acc && tries < 8) begin
                step(1'b1, i == 0, pat(i), acc); tries++;
                n_cmp++;
                if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL rstmid_ctl @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
                if (exp_ctl[3]) begin n_cmp++; if (obs_px !== exp_px) begin n_bad++; $display("FAIL rstmid_col @%0t: got %h want %h", $time, obs_px, exp_px); end end
                if (obs_ctl[3] === 1'b1) begin if (nfv == 0) first_col = obs_px; last_col = obs_px; nfv++; end
            end
            if (!acc) begin n_cmp++; n_bad++; $display("FAIL rstmid_accept: beat %0d not accepted", i); end
        end
        for (int k = 1; k <= F + 3; k++) begin
            step(1'b0, 1'b0, 8'h00, acc);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL rstmid_drain @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
        end
        n_cmp++; if (nfv !== 16) begin n_bad++; $display("FAIL rstmid_fv_count: got %0d want 16", nfv); end
        n_cmp++; if (first_col !== 40'h0010203040) begin n_bad++; $display("FAIL rstmid_first_col: got %h want 0010203040", first_col); end
        n_cmp++; if (last_col !== 40'h1727374757) begin n_bad++; $display("FAIL rstmid_last_col: got %h want 1727374757", last_col); end
    endtask

    task automatic test_back_to_back();
        bit acc; int nfv = 0; int kd = -1; int kacc = -1; int nlow = 0;
        logic [7:0] p0 = 8'($urandom);
        for (int i = 0; i < W * H; i++) begin
            int tries = 0; acc = 1'b0;
            while (!acc && tries < 8) begin
                step(1'b1, i == 0, 8'($urandom), acc); tries++;
                n_cmp++;
                if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL b2b_ctl1 @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
                if (exp_ctl[3]) begin n_cmp++; if (obs_px !== exp_px) begin n_bad++; $display("FAIL b2b_col1 @%0t: got %h want %h", $time, obs_px, exp_px); end end
            end
            if (!acc) begin n_cmp++; n_bad++; $display("FAIL b2b_accept1: beat %0d not accepted", i); end
        end
        for (int k = 1; k <= F + 10 && kacc < 0; k++) begin
            step(1'b1, 1'b1, p0, acc);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL b2b_hold @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
            if (obs_ctl[1] === 1'b1 && kd < 0) kd = k;
            if (obs_ctl[4] === 1'b0) nlow++;
            if (acc) kacc = k;
        end
        n_cmp++; if (kd !== F) begin n_bad++; $display("FAIL b2b_done_delay: got %0d want %0d", kd, F); end
        n_cmp++; if (nlow !== F) begin n_bad++; $display("FAIL b2b_ready_low: got %0d want %0d", nlow, F); end
        n_cmp++; if (kacc !== F + 2) begin n_bad++; $display("FAIL b2b_restart: got %0d want %0d", kacc, F + 2); end
        for (int i = 1; i < W * H; i++) begin
            int tries = 0; acc = 1'b0;
            while (!acc && tries < 8) begin
                step(1'b1, 1'b0, 8'($urandom), acc); tries++;
                n_cmp++;
                if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL b2b_ctl2 @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
                if (exp_ctl[3]) begin n_cmp++; if (obs_px !== exp_px) begin n_bad++; $display("FAIL b2b_col2 @%0t: got %h want %h", $time, obs_px, exp_px); end end
                if (obs_ctl[3] === 1'b1) nfv++;
            end
            if (!acc) begin n_cmp++; n_bad++; $display("FAIL b2b_accept2: beat %0d not accepted", i); end
        end
        for (int k = 1; k <= F + 3; k++) begin
            step(1'b0, 1'b0, 8'h00, acc);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL b2b_drain @%0t: got %b want %b", $time, obs_ctl, exp_ctl); end
        end
        n_cmp++; if (nfv !== 16) begin n_bad++; $display("FAIL b2b_fv_count: got %0d want 16", nfv); end
    endtask

    initial begin
        rst = 1'b0;
        bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_pixel = 8'h00;
        test_reset();
        test_basic();
        test_gaps();
        test_idle_junk();
        test_premature_sof();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fir_line_sequencer.md
# fir_line_sequencer

Front-end sequencer for the 5x5 cascaded systolic FIR. It accepts a raster pixel stream (one pixel per accepted beat, row-major, frame marked by start-of-frame) and holds the four previous image lines in chained line buffers. Each cycle it presents a vertically aligned 5-pixel column plus `in_valid` to the filter's `pixel0..pixel4` / `in_valid` inputs. It also gates the input, flushes the filter pipeline at end of frame, and reports frame completion.

## Interface
- `IMG_WIDTH`, default 640: pixels per line, range 5..4096.
- `IMG_HEIGHT`, default 480: lines per frame, range 5..4096.
- `FLUSH_CYCLES`, default 12: cycles from last filter input to last filter output.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `s_pixel`  in  8  input pixel.
- `s_valid`  in  1  input beat valid.
- `s_sof`  in  1  start of frame; qualified by `s_valid`.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `pixel0`..`pixel4`  out  8 each  column to the filter; `pixel0` is line r-4, `pixel4` is line r (current).
- `fir_valid`  out  1  drives the filter's `in_valid`.
- `busy`  out  1  high in RUN and FLUSH.
- `frame_done`  out  1  one-cycle pulse when the flush completes.
- `sof_err`  out  1  one-cycle pulse on a premature start of frame.

## Operation
- Counters:
  - `col` is 0..IMG_WIDTH-1, width clog2(IMG_WIDTH).
  - `row` is 0..IMG_HEIGHT-1, width clog2(IMG_HEIGHT).
  - Both advance only on an accepted beat in RUN. `col` wraps to 0 and increments `row`.
- Line buffers:
  - LB3..LB0, each IMG_WIDTH x 8, read-before-write at address `col`.
  - On an accepted beat: LB3[col] <= s_pixel, LB2[col] <= old LB3[col], LB1[col] <= old LB2[col], LB0[col] <= old LB1[col].
  - Contents are not reset.
- Output register, loaded on every accepted beat in RUN:
  - pixel4 <= s_pixel, pixel3 <= old LB3[col], pixel2 <= old LB2[col], pixel1 <= old LB1[col], pixel0 <= old LB0[col].
  - `fir_valid` <= (row >= 4).
  - On a cycle with no accepted beat: `fir_valid` <= 0 and pixel registers hold.
- States (encoded FSM):
  - IDLE: `s_ready`=1. A beat with `s_sof`=1 is written as pixel (0,0) and moves to RUN. A beat without `s_sof` is discarded (no LB write, no `fir_valid`).
  - RUN: `s_ready`=1. The beat at (IMG_WIDTH-1, IMG_HEIGHT-1) moves to FLUSH and loads the flush counter with FLUSH_CYCLES.
  - FLUSH: `s_ready`=0. The counter decrements each cycle. At 1, `frame_done` is pulsed and the FSM goes to IDLE.
- Premature SOF: a beat in RUN with `s_sof`=1 at any position other than (0,0) pulses `sof_err`. That beat becomes pixel (0,0) of a new frame; `row`/`col` restart, and the FSM stays in RUN.
- The `s_sof` bit on the very first beat of a frame entered from IDLE is not an error.
- Rows 0..3 produce no `fir_valid`, so stale line-buffer data from a previous frame never reaches the filter.

## Timing
- Reset values: `s_ready`=0, `pixel0..4`=0, `fir_valid`=0, `busy`=0, `frame_done`=0, `sof_err`=0, state IDLE, counters 0.
  - `s_ready` rises on the first clock after deassertion.
- Latency: an accepted beat at edge N gives its column and `fir_valid` on outputs after edge N; the filter samples it at edge N+1.
- Throughput: one pixel per cycle in RUN. `s_valid` gaps produce `fir_valid`=0 cycles.
- `fir_valid` count per frame: IMG_WIDTH*(IMG_HEIGHT-4).
- FLUSH: `frame_done` rises exactly FLUSH_CYCLES cycles after the last beat's edge. `s_ready` rises the following cycle. `busy` falls with `frame_done`.
- Reset asserted mid-frame: all outputs clear immediately (asynchronous). The next frame requires `s_sof`.
- `s_valid` with `s_sof` in FLUSH is not accepted (`s_ready`=0). The source must hold it.

## Test plan
- IMG_WIDTH=8, IMG_HEIGHT=6, pixel = 16*row+col, continuous valid -> 16 `fir_valid` beats; the first column is pixel0..4 = 0x00,0x10,0x20,0x30,0x40; the last is 0x17,0x27,0x37,0x47,0x57; `frame_done` 12 cycles after the last beat.
- Same frame with `s_valid` toggling every other cycle -> identical column sequence; `fir_valid` only on cycles following accepts.
- Beats without `s_sof` in IDLE (3 beats) then a normal frame -> the 3 beats are ignored; output identical to the first scenario.
- `s_sof` reasserted at (3,2) mid-frame -> `sof_err` for 1 cycle; the new frame completes normally; no `fir_valid` until its row 4.
- `rst` low at row 5 col 2 -> all outputs 0 on the same edge; the following full frame matches the first scenario.
- Back-to-back frames with `s_sof` held valid during FLUSH -> `s_ready`=0 for FLUSH_CYCLES; the second frame starts the cycle after `frame_done`.
